// File: rtl/mem_write_checker_pkg.sv
// Shared state encoding and width helper for the data-memory store checker.
package mem_write_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  // ceil(log2(value)), never below 1 so single-entry configs still get a real index bit
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_write_checker_exp_store_table.sv
// Purpose: expectation table of {addr, data} pairs, one sync write port, one async read port.
// Latency: write visible the cycle after wr_en; read is combinational.
// Backpressure: none, writes always accepted; storage is deliberately not reset.
module exp_store_table
  import mem_write_checker_pkg::*;
#(
  parameter int  AW    = 10,
  parameter int  DW    = 32,
  parameter int  DEPTH = 8,
  localparam int IW    = clog2_min1(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [AW+DW-1:0] wr_dat,
  input  logic [IW-1:0]    rd_idx,
  output logic [AW+DW-1:0] rd_dat
);

  logic [AW+DW-1:0] entries [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_idx) < DEPTH)) begin
      entries[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = (int'(rd_idx) < DEPTH) ? entries[rd_idx] : '0;

endmodule

// File: rtl/mem_write_checker.sv
// Purpose: in-order checker of snooped data-memory stores against a programmed expectation table.
// Latency: each store's outcome is registered on the edge that samples it (visible next cycle).
// Backpressure: none; passive snoop, never stalls the store bus.
module mem_write_checker
  import mem_write_checker_pkg::*;
#(
  parameter int  n          = 10,
  parameter int  m          = 32,
  parameter int  NUM_CHECKS = 8,
  parameter int  TIMEOUT    = 4096,
  localparam int IW         = clog2_min1(NUM_CHECKS),
  localparam int WW         = clog2_min1(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_idx,
  input  logic [n-1:0]  prog_addr,
  input  logic [m-1:0]  prog_data,
  input  logic [IW:0]   num_exp,
  input  logic          start,
  input  logic          memwr,
  input  logic [n-1:0]  addr,
  input  logic [m-1:0]  write_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic          timeout,
  output logic [IW:0]   check_cnt,
  output logic [IW-1:0] fail_idx,
  output logic [n-1:0]  fail_addr,
  output logic [m-1:0]  fail_data
);

  localparam logic [IW:0]   MAX_EXP  = (IW + 1)'(NUM_CHECKS);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cnt_q, cnt_d, nexp_q, nexp_d, cnt_inc;
  logic [WW-1:0] wd_q, wd_d, wd_inc;
  logic          pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic [IW-1:0] fidx_q, fidx_d;
  logic [n-1:0]  faddr_q, faddr_d;
  logic [m-1:0]  fdata_q, fdata_d;

  logic [n+m-1:0] exp_entry;
  logic           tbl_we;
  logic           hit;

  assign tbl_we = prog_we && (state_q == ST_IDLE);

  exp_store_table #(
    .AW    (n),
    .DW    (m),
    .DEPTH (NUM_CHECKS)
  ) u_table (
    .clk    (clk),
    .wr_en  (tbl_we),
    .wr_idx (prog_idx),
    .wr_dat ({prog_addr, prog_data}),
    .rd_idx (ptr_q),
    .rd_dat (exp_entry)
  );

  assign hit     = ({addr, write_data} == exp_entry);
  assign cnt_inc = cnt_q + 1'b1;
  assign wd_inc  = wd_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      nexp_q  <= '0;
      wd_q    <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      fidx_q  <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      nexp_q  <= nexp_d;
      wd_q    <= wd_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      fidx_q  <= fidx_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    nexp_d  = nexp_q;
    wd_d    = wd_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
    fidx_d  = fidx_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;

    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (start) begin
          ptr_d   = '0;
          cnt_d   = '0;
          wd_d    = '0;
          nexp_d  = num_exp;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          fidx_d  = '0;
          faddr_d = '0;
          fdata_d = '0;
          // an empty or oversized run can never pass, so report it straight away
          if ((num_exp == '0) || (num_exp > MAX_EXP)) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (memwr && hit) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_inc;
          wd_d  = '0;
          if (cnt_inc == nexp_q) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end
        end else if (memwr) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          fidx_d  = ptr_q;
          faddr_d = addr;
          fdata_d = write_data;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_inc;
          if (wd_inc == WD_LIMIT) begin
            state_d = ST_TIMEOUT;
            to_d    = 1'b1;
            fail_d  = 1'b1;
            fidx_d  = ptr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_CHECK);
  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = to_q;
  assign check_cnt = cnt_q;
  assign fail_idx  = fidx_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed plus randomized bench for mem_write_checker against a cycle-level behavioural model.
module tb_mem_write_checker;

  localparam int N  = 10;
  localparam int M  = 32;
  localparam int NC = 8;
  localparam int TO = 16;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, prog_we, start, memwr;
  logic [IW-1:0] prog_idx;
  logic [N-1:0]  prog_addr, addr;
  logic [M-1:0]  prog_data, write_data;
  logic [IW:0]   num_exp;
  logic          busy, done, pass, fail, timeout;
  logic [IW:0]   check_cnt;
  logic [IW-1:0] fail_idx;
  logic [N-1:0]  fail_addr;
  logic [M-1:0]  fail_data;

  mem_write_checker #(.n(N), .m(M), .NUM_CHECKS(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_idx(prog_idx), .prog_addr(prog_addr),
    .prog_data(prog_data), .num_exp(num_exp), .start(start), .memwr(memwr), .addr(addr),
    .write_data(write_data), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .check_cnt(check_cnt), .fail_idx(fail_idx), .fail_addr(fail_addr),
    .fail_data(fail_data)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference: expectation list plus run status
  logic [N-1:0] t_addr [NC];
  logic [M-1:0] t_data [NC];
  bit           m_busy, m_done, m_pass, m_fail, m_to;
  int           m_cnt, m_fidx, m_nexp, since;
  logic [N-1:0] m_faddr;
  logic [M-1:0] m_fdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
      m_cnt = 0; m_fidx = 0; m_faddr = '0; m_fdata = '0; since = 0;
      return;
    end
    if (m_busy) begin
      if (memwr) begin
        if (addr == t_addr[m_cnt] && write_data == t_data[m_cnt]) begin
          m_cnt++;
          since = 0;
          if (m_cnt == m_nexp) begin m_busy = 0; m_done = 1; m_pass = 1; end
        end else begin
          m_busy = 0; m_done = 1; m_fail = 1;
          m_fidx = m_cnt; m_faddr = addr; m_fdata = write_data;
        end
      end else begin
        since++;
        if (since == TO) begin
          m_busy = 0; m_done = 1; m_fail = 1; m_to = 1; m_fidx = m_cnt;
        end
      end
    end else begin
      if (prog_we && !m_done) begin
        t_addr[prog_idx] = prog_addr;
        t_data[prog_idx] = prog_data;
      end
      if (start) begin
        m_cnt = 0; since = 0; m_pass = 0; m_fail = 0; m_to = 0;
        m_fidx = 0; m_faddr = '0; m_fdata = '0;
        m_nexp = int'(num_exp);
        if (m_nexp == 0 || m_nexp > NC) begin
          m_busy = 0; m_done = 1; m_fail = 1;
        end else begin
          m_busy = 1; m_done = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("fail", fail, m_fail);
    chk("timeout", timeout, m_to);
    chk("check_cnt", check_cnt, m_cnt);
    chk("fail_idx", fail_idx, m_fidx);
    chk("fail_addr", fail_addr, m_faddr);
    chk("fail_data", fail_data, m_fdata);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    rst = 0; prog_we = 0; start = 0; memwr = 0;
  endtask

  task automatic prog(input int idx, input int a, input int d);
    prog_we = 1; prog_idx = IW'(idx); prog_addr = N'(a); prog_data = M'(d);
    step();
  endtask

  task automatic go(input int k);
    start = 1; num_exp = (IW + 1)'(k);
    step();
  endtask

  task automatic store(input int a, input int d);
    memwr = 1; addr = N'(a); write_data = M'(d);
    step();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    rst = 1; prog_we = 0; start = 0; memwr = 0; prog_idx = '0; prog_addr = '0;
    prog_data = '0; num_exp = '0; addr = '0; write_data = '0;
    for (int i = 0; i < NC; i++) begin t_addr[i] = '0; t_data[i] = '0; end
    step();
    rst = 1; step();
    chk("reset_state", {busy, done, pass, fail, timeout}, 5'b0);

    // basic two-store pass
    prog(0, 96, 2); prog(1, 92, 4);
    go(2); store(96, 2); store(92, 4);
    chk("t1_pass", pass, 1); chk("t1_cnt", check_cnt, 2); chk("t1_fail", fail, 0);
    idle(2);

    // rerun from PASS with wrong second data
    go(2); store(96, 2); store(92, 5);
    chk("t2_fail", fail, 1); chk("t2_idx", fail_idx, 1);
    chk("t2_addr", fail_addr, 92); chk("t2_data", fail_data, 5); chk("t2_pass", pass, 0);

    // watchdog fires exactly TO cycles after start
    go(2); idle(TO - 1);
    chk("t3_early", timeout, 0);
    idle(1);
    chk("t3_timeout", timeout, 1); chk("t3_fail", fail, 1); chk("t3_idx", fail_idx, 0);
    idle(3);

    // store while idle is ignored; table survives reset
    rst = 1; step();
    store(96, 2); chk("t4_idle_done", done, 0);
    go(2); store(96, 2); store(92, 4); chk("t4_pass", pass, 1);

    // reset mid-run, then rerun
    go(2); store(96, 2); rst = 1; step();
    chk("t5_rst", {busy, done, pass, fail, timeout, check_cnt}, 9'b0);
    go(2); store(96, 2); store(92, 4); chk("t5_pass", pass, 1);

    // out-of-range num_exp fails immediately
    go(0);  chk("t6_zero_fail", fail, 1); chk("t6_zero_idx", fail_idx, 0);
    go(NC + 1); chk("t6_big_fail", fail, 1); chk("t6_big_done", done, 1);
    go(15); chk("t6_max_fail", fail, 1);

    // program and start in the same IDLE cycle
    rst = 1; step();
    prog_we = 1; prog_idx = '0; prog_addr = N'(96); prog_data = M'(7);
    start = 1; num_exp = 1; step();
    store(96, 7); chk("t7_same_cycle_pass", pass, 1);

    // full-depth run with gaps
    rst = 1; step();
    for (int k = 0; k < NC; k++) prog(k, 8 * k + 4, 100 + k);
    go(NC);
    for (int k = 0; k < NC; k++) begin
      idle(k % 3);
      store(8 * k + 4, 100 + k);
    end
    chk("t8_full_pass", pass, 1); chk("t8_full_cnt", check_cnt, NC);

    // randomized runs
    for (int it = 0; it < 30; it++) begin
      int ne, sel, r, gap;
      rst = 1; step();
      ne = $urandom_range(1, NC);
      for (int k = 0; k < ne; k++) begin
        prog_we = 1; prog_idx = IW'(k);
        prog_addr = N'(4 * $urandom_range(0, 7)); prog_data = M'($urandom_range(0, 3));
        if (k == ne - 1 && $urandom_range(0, 1) == 1) begin
          start = 1; num_exp = (IW + 1)'(ne);
        end
        step();
      end
      if (!m_busy && !m_done) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) go(0);
        else if (sel == 1) go($urandom_range(NC + 1, 15));
        else go($urandom_range(1, ne));
      end
      for (int c = 0; c < 80 && m_busy; c++) begin
        r = $urandom_range(0, 19);
        if ($urandom_range(0, 7) == 0) begin
          prog_we = 1; prog_idx = IW'($urandom_range(0, NC - 1));
          prog_addr = N'($urandom_range(0, 1023)); prog_data = M'($urandom);
        end
        if ($urandom_range(0, 9) == 0) begin
          start = 1; num_exp = (IW + 1)'($urandom_range(1, NC));
        end
        if (r < 12) begin
          memwr = 1; addr = t_addr[m_cnt]; write_data = t_data[m_cnt]; step();
        end else if (r < 14) begin
          memwr = 1; addr = N'(4 * $urandom_range(0, 7)); write_data = M'($urandom_range(0, 3));
          step();
        end else if (r < 19) begin
          step();
        end else begin
          gap = $urandom_range(5, 20);
          for (int g = 0; g < gap; g++) step();
        end
      end
      for (int c = 0; c < 3; c++) begin
        memwr = 1; addr = N'($urandom_range(0, 1023)); write_data = M'($urandom);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
